// File: rtl/fifo_queue_ctrl_if.sv
// rtl/fifo_queue_ctrl_if.sv - push/pop request, RAM port and status signals of the queue controller
interface fifo_queue_ctrl_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
);
    logic              wr_req;
    logic              rd_req;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] ram_q;
    logic              ram_wren;
    logic [ADDR_W-1:0] ram_wraddr;
    logic [DATA_W-1:0] ram_wrdata;
    logic [ADDR_W-1:0] ram_rdaddr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic [ADDR_W:0]   count;
    logic              empty;
    logic              full;
    logic              overflow;
    logic              underflow;

    modport master (
        output wr_req, rd_req, wr_data, ram_q,
        input  ram_wren, ram_wraddr, ram_wrdata, ram_rdaddr,
        input  rd_data, rd_valid, count, empty, full, overflow, underflow
    );

    modport slave (
        input  wr_req, rd_req, wr_data, ram_q,
        output ram_wren, ram_wraddr, ram_wrdata, ram_rdaddr,
        output rd_data, rd_valid, count, empty, full, overflow, underflow
    );
endinterface

// File: rtl/fifo_queue_ctrl.sv
// rtl/fifo_queue_ctrl.sv - circular-queue FIFO controller sequencing a dual-port RAM with 1-cycle read
module fifo_queue_ctrl #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    fifo_queue_ctrl_if.slave   bus
);
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(2**ADDR_W);

    typedef enum logic {IDLE, RD_WAIT} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    logic full, empty, push_ok, pop_ok;

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);

    // Gated by reset so the RAM sees no write strobe while the controller is held in reset.
    assign push_ok = reset && bus.wr_req && !full;
    assign pop_ok  = reset && bus.rd_req && !empty && (state_q == IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pop_ok) state_d = RD_WAIT;
            RD_WAIT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (push_ok) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);

        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (ADDR_W+1)'(1);
            2'b01:   count_d = count_q - (ADDR_W+1)'(1);
            default: count_d = count_q;
        endcase

        // ram_q holds the head word during RD_WAIT, addressed by the pre-increment pointer.
        if (state_q == RD_WAIT) begin
            rd_data_d  = bus.ram_q;
            rd_valid_d = 1'b1;
        end

        if (bus.wr_req && full) overflow_d = 1'b1;
        if (bus.rd_req && empty && (state_q == IDLE)) underflow_d = 1'b1;
    end

    assign bus.ram_wren   = push_ok;
    assign bus.ram_wraddr = wr_ptr_q;
    assign bus.ram_wrdata = bus.wr_data;
    assign bus.ram_rdaddr = rd_ptr_q;
    assign bus.rd_data    = rd_data_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.count      = count_q;
    assign bus.empty      = empty;
    assign bus.full       = full;
    assign bus.overflow   = overflow_q;
    assign bus.underflow  = underflow_q;
endmodule

// File: tb/tb_fifo_queue_ctrl.sv
// tb/tb_fifo_queue_ctrl.sv - randomized and directed bench for fifo_queue_ctrl against a queue model
module tb_fifo_queue_ctrl;
    localparam int ADDR_W = 3;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 2**ADDR_W;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad = 0;

    fifo_queue_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    fifo_queue_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Dual-port RAM with registered read, as the controller expects downstream.
    logic [DATA_W-1:0] mem [DEPTH];
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        bus.ram_q = '0;
    end
    always @(posedge clk) begin
        if (bus.ram_wren) mem[bus.ram_wraddr] <= bus.ram_wrdata;
        bus.ram_q <= mem[bus.ram_rdaddr];
    end

    // Reference: the queue contents plus the pending read and sticky flags.
    logic [DATA_W-1:0] m_q[$];
    int                m_wp, m_rp;
    bit                m_busy, m_valid, m_ovf, m_udf;
    logic [DATA_W-1:0] m_pend, m_rdata;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_wp = 0; m_rp = 0;
        m_busy = 0; m_valid = 0; m_ovf = 0; m_udf = 0;
        m_pend = '0; m_rdata = '0;
    endtask

    task automatic compare(input logic wr, input logic [DATA_W-1:0] d);
        bit f, e;
        f = (m_q.size() == DEPTH);
        e = (m_q.size() == 0);
        chk("count", 32'(bus.count), 32'(m_q.size()));
        chk("empty", 32'(bus.empty), 32'(e));
        chk("full", 32'(bus.full), 32'(f));
        chk("ram_wren", 32'(bus.ram_wren), 32'(wr && !f));
        if (wr && !f) begin
            chk("ram_wraddr", 32'(bus.ram_wraddr), 32'(m_wp));
            chk("ram_wrdata", 32'(bus.ram_wrdata), 32'(d));
        end
        chk("ram_rdaddr", 32'(bus.ram_rdaddr), 32'(m_rp));
        chk("rd_valid", 32'(bus.rd_valid), 32'(m_valid));
        chk("rd_data", 32'(bus.rd_data), 32'(m_rdata));
        chk("overflow", 32'(bus.overflow), 32'(m_ovf));
        chk("underflow", 32'(bus.underflow), 32'(m_udf));
    endtask

    task automatic model_update(input logic wr, input logic rd, input logic [DATA_W-1:0] d);
        bit f, e, push, pop, was_busy;
        f = (m_q.size() == DEPTH);
        e = (m_q.size() == 0);
        was_busy = m_busy;
        push = wr && !f;
        pop  = rd && !e && !was_busy;
        m_valid = was_busy;
        if (was_busy) m_rdata = m_pend;
        if (pop) begin
            m_pend = m_q.pop_front();
            m_rp = (m_rp + 1) % DEPTH;
        end
        if (push) begin
            m_q.push_back(d);
            m_wp = (m_wp + 1) % DEPTH;
        end
        m_busy = pop;
        if (wr && f) m_ovf = 1;
        if (rd && e && !was_busy) m_udf = 1;
    endtask

    task automatic step(input logic wr, input logic rd, input logic [DATA_W-1:0] d);
        bus.wr_req = wr; bus.rd_req = rd; bus.wr_data = d;
        @(negedge clk);
        compare(wr, d);
        @(posedge clk);
        model_update(wr, rd, d);
        #1;
    endtask

    task automatic reset_dut();
        bus.wr_req = 1'b1; bus.rd_req = 1'b0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
    endtask

    task automatic spaced_pops(input int n);
        for (int i = 0; i < n; i++) begin
            step(0, 1, 8'h00);
            step(0, 0, 8'h00);
        end
    endtask

    initial begin
        bus.wr_req = 1'b1; bus.rd_req = 1'b0; bus.wr_data = 8'h5A;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_empty", 32'(bus.empty), 1);
        chk("rst_full", 32'(bus.full), 0);
        chk("rst_wren", 32'(bus.ram_wren), 0);
        chk("rst_valid", 32'(bus.rd_valid), 0);
        chk("rst_flags", 32'({bus.overflow, bus.underflow}), 0);
        @(posedge clk); #1;
        reset = 1'b1;

        step(1, 0, 8'h11); step(1, 0, 8'h22); step(1, 0, 8'h33);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 8'h00); step(0, 0, 8'h00); step(0, 0, 8'h00);
        end
        step(0, 0, 8'h00);
        chk("order_empty", 32'(bus.empty), 1);

        reset_dut();
        for (int i = 0; i < 8; i++) step(1, 0, 8'hA0 + 8'(i));
        chk("fill_full", 32'(bus.full), 1);
        step(1, 0, 8'hEE);
        chk("fill_ovf", 32'(bus.overflow), 1);
        step(0, 1, 8'h00); step(0, 0, 8'h00);
        step(1, 0, 8'hB0);
        spaced_pops(8);
        step(0, 0, 8'h00);
        chk("wrap_drained", 32'(bus.count), 0);

        step(0, 1, 8'h00);
        step(1, 1, 8'hC1);
        step(0, 0, 8'h00);
        chk("udf_count", 32'(bus.count), 1);
        chk("udf_flag", 32'(bus.underflow), 1);

        for (int i = 0; i < 3; i++) step(1, 0, 8'hC2 + 8'(i));
        step(1, 1, 8'hD0);
        step(0, 0, 8'h00); step(0, 0, 8'h00);
        chk("mid_count", 32'(bus.count), 4);
        for (int i = 0; i < 4; i++) step(1, 0, 8'hD1 + 8'(i));
        step(1, 1, 8'hDF);
        step(0, 0, 8'h00); step(0, 0, 8'h00);
        chk("full_sim_count", 32'(bus.count), 7);

        spaced_pops(4);
        step(0, 1, 8'h00); step(0, 1, 8'h00);
        step(0, 0, 8'h00); step(0, 0, 8'h00);
        chk("b2b_count", 32'(bus.count), 2);

        step(0, 1, 8'h00);
        bus.wr_req = 1'b1;
        reset = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.rd_valid), 0);
        chk("arst_count", 32'(bus.count), 0);
        chk("arst_empty", 32'(bus.empty), 1);
        chk("arst_wren", 32'(bus.ram_wren), 0);
        chk("arst_ptrs", 32'({bus.ram_wraddr, bus.ram_rdaddr}), 0);
        chk("arst_data", 32'(bus.rd_data), 0);
        chk("arst_flags", 32'({bus.overflow, bus.underflow}), 0);
        @(posedge clk); #1;
        chk("arst_novalid", 32'(bus.rd_valid), 0);
        reset = 1'b1;
        model_reset();

        for (int blk = 0; blk < 16; blk++) begin
            int bias;
            bias = $urandom_range(10, 90);
            for (int c = 0; c < 50; c++) begin
                logic w, r;
                w = ($urandom_range(0, 99) < bias);
                r = ($urandom_range(0, 99) < (100 - bias));
                step(w, r, 8'($urandom));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
